// File: rtl/fm_nco_pkg.sv
// Shared constants and helpers for the FM NCO: saturating frequency add and
// quarter-wave sine table generation.
package fm_nco_pkg;

    localparam int unsigned PHASE_W_DFLT = 32;
    localparam logic [PHASE_W_DFLT-1:0] QTR = 32'(1) << (PHASE_W_DFLT - 2);
    localparam real PI = 3.14159265358979323846;

    typedef struct packed {
        logic        sat;
        logic [31:0] val;
    } sat_res_t;

    // 33-bit sum; the top two bits disagreeing means the 32-bit result overflowed.
    function automatic sat_res_t sat32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sat_res_t    res;
        sum = {a[31], a} + {b[31], b};
        res.sat = sum[32] ^ sum[31];
        if (!res.sat) begin
            res.val = sum[31:0];
        end else if (sum[32]) begin
            res.val = 32'h8000_0000;
        end else begin
            res.val = 32'h7FFF_FFFF;
        end
        return res;
    endfunction

    // Half-sample offset keeps every entry non-zero and the table symmetric.
    function automatic int rom_entry(input int k, input int aw, input int ow);
        real ang;
        real amp;
        ang = PI / 2.0 * (real'(k) + 0.5) / real'(1 << aw);
        amp = real'((1 << (ow - 1)) - 1);
        return $rtoi($sin(ang) * amp + 0.5);
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Dual-read-port quarter-wave sine ROM with one-cycle registered read.
module quarter_sine_rom
    import fm_nco_pkg::*;
#(
    parameter int unsigned LUT_AW = 10,
    parameter int unsigned OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LUT_AW-1:0] i_addr_a,
    input  logic [LUT_AW-1:0] i_addr_b,
    output logic [OUT_W-2:0]  o_data_a,
    output logic [OUT_W-2:0]  o_data_b
);

    logic [OUT_W-2:0] w_table [2**LUT_AW];
    logic [OUT_W-2:0] r_data_a;
    logic [OUT_W-2:0] r_data_b;

    for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_table
        assign w_table[k] = (OUT_W-1)'(rom_entry(k, LUT_AW, OUT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_a <= '0;
            r_data_b <= '0;
        end else begin
            r_data_a <= w_table[i_addr_a];
            r_data_b <= w_table[i_addr_b];
        end
    end

    assign o_data_a = r_data_a;
    assign o_data_b = r_data_b;

endmodule

// File: rtl/fm_nco_iq.sv
// FM NCO: saturating carrier+modulation frequency word, 32-bit phase accumulator
// and a 3-stage quadrature cos/sin lookup.
module fm_nco_iq
    import fm_nco_pkg::*;
#(
    parameter int unsigned PHASE_W = PHASE_W_DFLT,
    parameter int unsigned LUT_AW  = 10,
    parameter int unsigned OUT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [PHASE_W-1:0] f0,
    input  logic signed [PHASE_W-1:0] fm_in,
    input  logic                      fm_stb,
    input  logic                      en,
    input  logic                      phase_clr,
    output logic signed [OUT_W-1:0]   i_out,
    output logic signed [OUT_W-1:0]   q_out,
    output logic                      out_valid,
    output logic                      sat_flag
);

    logic [PHASE_W-1:0]  r_fm_hold;
    logic [PHASE_W-1:0]  r_freq;
    logic [PHASE_W-1:0]  r_phase;
    logic                r_sat;
    sat_res_t            w_sum;
    logic [LUT_AW+1:0]   w_top_q;
    logic [LUT_AW+1:0]   w_top_i;
    logic [LUT_AW-1:0]   r_s1_idx_q;
    logic [LUT_AW-1:0]   r_s1_idx_i;
    logic                r_s1_neg_q;
    logic                r_s1_neg_i;
    logic                r_s1_en;
    logic [OUT_W-2:0]    w_rom_q;
    logic [OUT_W-2:0]    w_rom_i;
    logic                r_s2_neg_q;
    logic                r_s2_neg_i;
    logic                r_s2_en;
    logic [OUT_W-1:0]    w_mag_q;
    logic [OUT_W-1:0]    w_mag_i;
    logic signed [OUT_W-1:0] r_q_out;
    logic signed [OUT_W-1:0] r_i_out;
    logic                r_valid;

    assign w_sum = sat32(f0, r_fm_hold);

    // The +90 degree offset only touches the quadrant bits, so add it to the top slice.
    assign w_top_q = r_phase[PHASE_W-1 -: LUT_AW+2];
    assign w_top_i = w_top_q + {2'b01, {LUT_AW{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fm_hold <= '0;
            r_freq    <= '0;
            r_sat     <= 1'b0;
            r_phase   <= '0;
        end else begin
            if (fm_stb) begin
                r_fm_hold <= fm_in;
            end
            r_freq <= w_sum.val;
            if (w_sum.sat) begin
                r_sat <= 1'b1;
            end
            if (phase_clr) begin
                r_phase <= '0;
            end else if (en) begin
                r_phase <= r_phase + r_freq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_idx_q <= '0;
            r_s1_idx_i <= '0;
            r_s1_neg_q <= 1'b0;
            r_s1_neg_i <= 1'b0;
            r_s1_en    <= 1'b0;
        end else begin
            r_s1_idx_q <= w_top_q[LUT_AW] ? ~w_top_q[LUT_AW-1:0] : w_top_q[LUT_AW-1:0];
            r_s1_idx_i <= w_top_i[LUT_AW] ? ~w_top_i[LUT_AW-1:0] : w_top_i[LUT_AW-1:0];
            r_s1_neg_q <= w_top_q[LUT_AW+1];
            r_s1_neg_i <= w_top_i[LUT_AW+1];
            r_s1_en    <= en;
        end
    end

    quarter_sine_rom #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_rom (
        .clk      (clk),
        .rst      (rst),
        .i_addr_a (r_s1_idx_q),
        .i_addr_b (r_s1_idx_i),
        .o_data_a (w_rom_q),
        .o_data_b (w_rom_i)
    );

    assign w_mag_q = {1'b0, w_rom_q};
    assign w_mag_i = {1'b0, w_rom_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_neg_q <= 1'b0;
            r_s2_neg_i <= 1'b0;
            r_s2_en    <= 1'b0;
            r_q_out    <= '0;
            r_i_out    <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_s2_neg_q <= r_s1_neg_q;
            r_s2_neg_i <= r_s1_neg_i;
            r_s2_en    <= r_s1_en;
            r_q_out    <= r_s2_neg_q ? -w_mag_q : w_mag_q;
            r_i_out    <= r_s2_neg_i ? -w_mag_i : w_mag_i;
            r_valid    <= r_s2_en;
        end
    end

    assign q_out     = r_q_out;
    assign i_out     = r_i_out;
    assign out_valid = r_valid;
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_fm_nco_iq.sv
// Directed bench for fm_nco_iq with hand-computed expected samples.
`timescale 1ns/1ps
module tb_fm_nco_iq;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] f0;
    logic signed [31:0] fm_in;
    logic               fm_stb;
    logic               en;
    logic               phase_clr;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;
    logic               out_valid;
    logic               sat_flag;

    int n_assert = 0;
    int n_fail   = 0;

    int exp_q[4] = '{25, 32767, -25, -32767};
    int exp_i[4] = '{32767, -25, -32767, 25};

    fm_nco_iq dut (
        .clk       (clk),
        .rst       (rst),
        .f0        (f0),
        .fm_in     (fm_in),
        .fm_stb    (fm_stb),
        .en        (en),
        .phase_clr (phase_clr),
        .i_out     (i_out),
        .q_out     (q_out),
        .out_valid (out_valid),
        .sat_flag  (sat_flag)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                   tag, obs, obs, exp, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; f0 = '0; fm_in = '0; fm_stb = 1'b0; phase_clr = 1'b0;
        tick(3);
        chk("rst_i", i_out, 0);
        chk("rst_q", q_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_phase", dut.r_phase, 0);

        // Idle carrier: phase stays 0
        rst = 1'b0; en = 1'b1;
        tick(1); chk("idle_valid_c1", out_valid, 0);
        tick(1); chk("idle_valid_c2", out_valid, 0);
        tick(1);
        chk("idle_q_c3", q_out, 25);
        chk("idle_i_c3", i_out, 32767);
        chk("idle_valid_c3", out_valid, 1);
        tick(1);
        chk("idle_q_c4", q_out, 25);
        chk("idle_i_c4", i_out, 32767);
        chk("idle_sat", sat_flag, 0);

        // Quarter-cycle step: 4-sample period, wraps through 2^32
        f0 = 32'sh4000_0000;
        tick(2); chk("quad_freq", dut.r_freq, 32'h4000_0000);
        phase_clr = 1'b1; tick(1); phase_clr = 1'b0;
        chk("quad_clr_phase", dut.r_phase, 0);
        tick(2);
        for (int s = 0; s < 5; s++) begin
            tick(1);
            chk($sformatf("quad_q%0d", s), q_out, exp_q[s % 4]);
            chk($sformatf("quad_i%0d", s), i_out, exp_i[s % 4]);
        end

        // Positive saturation, then sticky flag
        f0 = 32'sh7FFF_FFF0; fm_in = 32'sh0000_0100; fm_stb = 1'b1;
        tick(1); fm_stb = 1'b0;
        chk("sat_hold", dut.r_fm_hold, 32'h100);
        chk("sat_freq_e1", dut.r_freq, 32'h7FFF_FFF0);
        chk("sat_flag_e1", sat_flag, 0);
        tick(1);
        chk("sat_freq_e2", dut.r_freq, 32'h7FFF_FFFF);
        chk("sat_flag_e2", sat_flag, 1);
        f0 = '0; fm_in = '0; fm_stb = 1'b1;
        tick(1); fm_stb = 1'b0;
        tick(1);
        chk("sat_clear_freq", dut.r_freq, 0);
        chk("sat_sticky", sat_flag, 1);
        tick(4);
        chk("sat_sticky_late", sat_flag, 1);

        // fm_in without strobe is ignored; strobe shows in the phase 2 edges later
        f0 = 32'sh0000_0100; fm_in = 32'sh1000_0000;
        tick(2);
        chk("nostb_freq", dut.r_freq, 32'h100);
        phase_clr = 1'b1; tick(1); phase_clr = 1'b0;
        chk("nostb_ph0", dut.r_phase, 0);
        tick(1); chk("nostb_ph1", dut.r_phase, 32'h100);
        tick(1); chk("nostb_ph2", dut.r_phase, 32'h200);
        fm_stb = 1'b1; tick(1); fm_stb = 1'b0;
        chk("stb_hold", dut.r_fm_hold, 32'h1000_0000);
        chk("stb_ph_e0", dut.r_phase, 32'h300);
        tick(1);
        chk("stb_ph_e1", dut.r_phase, 32'h400);
        chk("stb_freq_e1", dut.r_freq, 32'h1000_0100);
        tick(1);
        chk("stb_ph_e2", dut.r_phase, 32'h1000_0500);

        // Clear together with en, then freeze with en low
        f0 = 32'sh0123_4567; fm_in = '0; fm_stb = 1'b1;
        tick(1); fm_stb = 1'b0;
        tick(2);
        chk("clr_freq", dut.r_freq, 32'h0123_4567);
        phase_clr = 1'b1; en = 1'b1; tick(1); phase_clr = 1'b0;
        chk("clr_phase", dut.r_phase, 0);
        tick(1);
        chk("clr_phase_e1", dut.r_phase, 32'h0123_4567);
        en = 1'b0;
        tick(2);
        chk("clr_q", q_out, 25);
        chk("clr_i", i_out, 32767);
        chk("clr_valid", out_valid, 1);
        tick(1);
        chk("frz_valid_drop", out_valid, 0);
        chk("frz_q_e4", q_out, 930);
        chk("frz_i_e4", i_out, 32754);
        tick(2);
        chk("frz_q_e6", q_out, 930);
        chk("frz_i_e6", i_out, 32754);
        chk("frz_valid_e6", out_valid, 0);
        chk("frz_phase", dut.r_phase, 32'h0123_4567);

        // Mid-stream reset
        en = 1'b1;
        tick(2);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("mrst_i", i_out, 0);
        chk("mrst_q", q_out, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_sat", sat_flag, 0);
        chk("mrst_freq", dut.r_freq, 0);
        tick(3);
        chk("mrst_q_c3", q_out, 25);
        chk("mrst_i_c3", i_out, 32767);
        chk("mrst_valid_c3", out_valid, 1);

        // Negative saturation
        f0 = 32'sh8000_0010; fm_in = 32'shFFFF_FF00; fm_stb = 1'b1;
        tick(1); fm_stb = 1'b0;
        chk("nsat_flag_e1", sat_flag, 0);
        tick(1);
        chk("nsat_freq", dut.r_freq, 32'h8000_0000);
        chk("nsat_flag", sat_flag, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
